fcore_program_loader: RTL and testbench



---
 rtl/fcore_loader_pkg.sv | 23 ++
 rtl/axi_if.sv | 57 +++++
 rtl/fcore_loader_addr_gen.sv | 85 ++++++++
 rtl/fcore_program_loader.sv | 155 +++++++++++++++
 tb/tb_fcore_program_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fcore_loader_pkg.sv
// fcore_loader_pkg
//   Shared types and AXI encodings for the fCore program loader.
//   - loader_state_e : shared read/write FSM states
//   - Burst*/Resp*   : AXI AxBURST and xRESP encodings
package fcore_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWData,
        StWResp,
        StRFetch,
        StRWait,
        StRData
    } loader_state_e;

    localparam logic [1:0] BurstFixed = 2'd0;
    localparam logic [1:0] BurstIncr  = 2'd1;
    localparam logic [1:0] BurstWrap  = 2'd2;

    localparam logic [1:0] RespOkay   = 2'd0;
    localparam logic [1:0] RespSlverr = 2'd2;

endpackage

// File: rtl/axi_if.sv
// AXI
//   ID-less AXI4 bundle carrying AW/W/B/AR/R channels.
//   Modports: slave (the loader), master (the driver side).
interface AXI #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/fcore_loader_addr_gen.sv
// fcore_loader_addr_gen
//   Burst address generator for the program loader.
//   i_load/i_addr/i_len/i_burst : start a burst (AXI byte address, AxLEN, AxBURST)
//   i_advance                   : step to the next beat
//   o_dec_word                  : word decoded from i_addr (valid in the load cycle)
//   o_word / o_next_word        : current beat word / word of the following beat
//   o_last                      : current beat is the final one
//   o_oor                       : latched burst falls outside program memory
module fcore_loader_addr_gen
    import fcore_loader_pkg::*;
#(
    parameter int unsigned         ADDR_WIDTH     = 32,
    parameter int unsigned         DATA_WIDTH     = 32,
    parameter int unsigned         MEM_ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_load,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic [7:0]                i_len,
    input  logic [1:0]                i_burst,
    input  logic                      i_advance,
    output logic [MEM_ADDR_WIDTH-1:0] o_dec_word,
    output logic [MEM_ADDR_WIDTH-1:0] o_word,
    output logic [MEM_ADDR_WIDTH-1:0] o_next_word,
    output logic                      o_last,
    output logic                      o_oor
);
    localparam int unsigned ByteShift = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH:0] MaxWord =
        {{(ADDR_WIDTH + 1 - MEM_ADDR_WIDTH){1'b0}}, {MEM_ADDR_WIDTH{1'b1}}};

    logic [ADDR_WIDTH-1:0]     w_offset;
    logic [ADDR_WIDTH-1:0]     w_word_full;
    logic [ADDR_WIDTH:0]       w_end;
    logic                      w_dec_oor;

    logic [MEM_ADDR_WIDTH-1:0] r_word;
    logic [7:0]                r_len;
    logic [7:0]                r_cnt;
    logic [1:0]                r_burst;
    logic                      r_oor;

    // Range check uses the full-width word so that bursts running past the
    // top of memory are caught instead of wrapping into low addresses.
    assign w_offset    = i_addr - BASE_ADDRESS;
    assign w_word_full = w_offset >> ByteShift;
    assign w_end       = {1'b0, w_word_full} + {{(ADDR_WIDTH - 7){1'b0}}, i_len};
    assign w_dec_oor   = (i_addr < BASE_ADDRESS) || (w_end > MaxWord);
    assign o_dec_word  = w_word_full[MEM_ADDR_WIDTH-1:0];

    always_comb begin
        o_next_word = r_word + MEM_ADDR_WIDTH'(1);
        case (r_burst)
            BurstFixed:           o_next_word = r_word;
            BurstIncr, BurstWrap: o_next_word = r_word + MEM_ADDR_WIDTH'(1);
            default:              o_next_word = r_word + MEM_ADDR_WIDTH'(1);
        endcase
    end

    assign o_word = r_word;
    assign o_last = (r_cnt == r_len);
    assign o_oor  = r_oor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_word  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= BurstIncr;
            r_oor   <= 1'b0;
        end else if (i_load) begin
            r_word  <= o_dec_word;
            r_len   <= i_len;
            r_cnt   <= '0;
            r_burst <= i_burst;
            r_oor   <= w_dec_oor;
        end else if (i_advance) begin
            r_word  <= o_next_word;
            r_cnt   <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/fcore_program_loader.sv
// fcore_program_loader
//   AXI4 slave mapping the fCore AXI port onto the single synchronous port of
//   the fCore program BRAM.
//   clock, reset     : system clock, asynchronous active-low reset
//   axi              : AXI4 slave (AW/W/B/AR/R, no IDs)
//   mem_en/mem_we    : memory enable / byte write enables
//   mem_addr         : memory word address
//   mem_wdata        : memory write data
//   mem_rdata        : memory read data, one cycle after a read enable
//   load_done        : one-cycle pulse after each accepted write response
module fcore_program_loader
    import fcore_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           MEM_ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS   = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    AXI.slave                         axi,
    output logic                      mem_en,
    output logic [DATA_WIDTH/8-1:0]   mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      load_done
);
    loader_state_e             r_state;
    logic [1:0]                r_bresp;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [1:0]                r_rresp;
    logic                      r_rlast;

    logic                      w_aw_hs;
    logic                      w_ar_hs;
    logic                      w_w_hs;
    logic                      w_w_final;
    logic                      w_r_hs;
    logic [MEM_ADDR_WIDTH-1:0] w_dec_word;
    logic [MEM_ADDR_WIDTH-1:0] w_word;
    logic [MEM_ADDR_WIDTH-1:0] w_next_word;
    logic                      w_last;
    logic                      w_oor;

    // Write address wins when both address channels are valid in IDLE.
    assign w_aw_hs   = (r_state == StIdle) && axi.awvalid;
    assign w_ar_hs   = (r_state == StIdle) && !axi.awvalid && axi.arvalid;
    assign w_w_hs    = (r_state == StWData) && axi.wvalid;
    assign w_w_final = axi.wlast || w_last;
    assign w_r_hs    = (r_state == StRData) && axi.rready;

    assign axi.awready = w_aw_hs;
    assign axi.arready = w_ar_hs;
    assign axi.wready  = (r_state == StWData);
    assign axi.bvalid  = (r_state == StWResp);
    assign axi.bresp   = r_bresp;
    assign axi.rvalid  = (r_state == StRData);
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;
    assign axi.rlast   = r_rlast;

    fcore_loader_addr_gen #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .BASE_ADDRESS   (BASE_ADDRESS)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .i_load      (w_aw_hs || w_ar_hs),
        .i_addr      (axi.awvalid ? axi.awaddr  : axi.araddr),
        .i_len       (axi.awvalid ? axi.awlen   : axi.arlen),
        .i_burst     (axi.awvalid ? axi.awburst : axi.arburst),
        .i_advance   (w_w_hs || w_r_hs),
        .o_dec_word  (w_dec_word),
        .o_word      (w_word),
        .o_next_word (w_next_word),
        .o_last      (w_last),
        .o_oor       (w_oor)
    );

    // Read enables are issued on the edge entering R_FETCH so the BRAM data
    // is on mem_rdata during R_WAIT, giving one beat every three cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_bresp   <= RespOkay;
            r_rdata   <= '0;
            r_rresp   <= RespOkay;
            r_rlast   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_done <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= '0;
            load_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_aw_hs) begin
                        r_state <= StWData;
                    end else if (w_ar_hs) begin
                        mem_en   <= 1'b1;
                        mem_addr <= w_dec_word;
                        r_state  <= StRFetch;
                    end
                end
                StWData: begin
                    if (w_w_hs) begin
                        mem_en    <= 1'b1;
                        mem_we    <= w_oor ? '0 : axi.wstrb;
                        mem_addr  <= w_word;
                        mem_wdata <= axi.wdata;
                        if (w_w_final) begin
                            // Early or late WLAST relative to AWLEN is an error.
                            r_bresp <= (w_oor || (axi.wlast != w_last)) ? RespSlverr : RespOkay;
                            r_state <= StWResp;
                        end
                    end
                end
                StWResp: begin
                    if (axi.bready) begin
                        load_done <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                StRFetch: begin
                    r_state <= StRWait;
                end
                StRWait: begin
                    r_rdata <= w_oor ? '0 : mem_rdata;
                    r_rresp <= w_oor ? RespSlverr : RespOkay;
                    r_rlast <= w_last;
                    r_state <= StRData;
                end
                StRData: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_state <= StIdle;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= w_next_word;
                            r_state  <= StRFetch;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fcore_program_loader.sv
module tb_fcore_program_loader;
    import fcore_loader_pkg::*;

    localparam int Tmo = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        load_done;

    AXI #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_bus ();

    fcore_program_loader #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MEM_ADDR_WIDTH (12),
        .BASE_ADDRESS   (32'h0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .axi       (axi_bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .load_done (load_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
        logic        consec;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rd_t;

    wr_t        exp_wr[$];
    logic [1:0] exp_b[$];
    rd_t        exp_r[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_wr_cyc = -10;
    logic [31:0] mem [0:4095];
    logic [31:0] wbuf [0:3];
    bit          ar_block = 1'b0;
    logic        prev_b_hs = 1'b0;
    logic        prev_r_stall = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no handshake within %0d cycles, required one", name, Tmo);
    endtask

    // Program memory model: byte-enabled writes, registered reads.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we == 4'h0) begin
                mem_rdata <= mem[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic mon_write();
        wr_t e;
        if (exp_wr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL mem_write: got write addr=%0d we=0x%h data=0x%08h, required none",
                     mem_addr, mem_we, mem_wdata);
        end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_we", 32'(mem_we), 32'(e.we));
            chk("wr_data", mem_wdata, e.data);
            if (e.consec) chk("wr_back_to_back", 32'(cyc), 32'(last_wr_cyc + 1));
        end
        last_wr_cyc = cyc;
    endtask

    task automatic mon_b();
        logic [1:0] e;
        if (exp_b.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_resp: got unexpected B resp=%0d, required none", axi_bus.bresp);
        end else begin
            e = exp_b.pop_front();
            chk("bresp", 32'(axi_bus.bresp), 32'(e));
        end
    endtask

    task automatic mon_r();
        rd_t e;
        if (exp_r.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL r_beat: got unexpected R data=0x%08h, required none", axi_bus.rdata);
        end else begin
            e = exp_r.pop_front();
            chk("rdata", axi_bus.rdata, e.data);
            chk("rresp", 32'(axi_bus.rresp), 32'(e.resp));
            chk("rlast", 32'(axi_bus.rlast), 32'(e.last));
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (!reset) begin
            prev_b_hs    <= 1'b0;
            prev_r_stall <= 1'b0;
        end else begin
            if (mem_en && mem_we != 4'h0) mon_write();
            if (axi_bus.bvalid && axi_bus.bready) mon_b();
            if (axi_bus.rvalid && axi_bus.rready) mon_r();
            if (load_done || prev_b_hs) chk("load_done", 32'(load_done), 32'(prev_b_hs));
            if (ar_block) chk("arready_blocked", 32'(axi_bus.arready), 32'h0);
            if (prev_r_stall) begin
                chk("r_hold_valid", 32'(axi_bus.rvalid), 32'h1);
                chk("r_hold_data", axi_bus.rdata, hold_data);
                chk("r_hold_last", 32'(axi_bus.rlast), 32'(hold_last));
            end
            prev_b_hs    <= axi_bus.bvalid && axi_bus.bready;
            prev_r_stall <= axi_bus.rvalid && !axi_bus.rready;
            hold_data    <= axi_bus.rdata;
            hold_last    <= axi_bus.rlast;
        end
    end

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
        exp_r.push_back('{data: d, resp: resp, last: last});
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb,
                             input logic [11:0] word0, input bit expect_wr,
                             input logic [1:0] exp_resp, input int bready_delay);
        int t;
        axi_bus.awaddr  = addr;
        axi_bus.awlen   = len;
        axi_bus.awburst = burst;
        axi_bus.awvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!axi_bus.awready && t < Tmo);
        if (!axi_bus.awready) fail_now("aw_handshake");
        @(posedge clock); #1;
        axi_bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi_bus.wdata  = wbuf[i];
            axi_bus.wstrb  = strb;
            axi_bus.wlast  = (i == int'(len));
            axi_bus.wvalid = 1'b1;
            t = 0;
            do begin
                @(negedge clock);
                t++;
            end while (!axi_bus.wready && t < Tmo);
            if (!axi_bus.wready) fail_now("w_handshake");
            if (expect_wr)
                exp_wr.push_back('{addr: (burst == BurstFixed) ? word0 : word0 + 12'(i),
                                   we: strb, data: wbuf[i], consec: (i != 0)});
            @(posedge clock); #1;
        end
        axi_bus.wvalid = 1'b0;
        axi_bus.wlast  = 1'b0;
        exp_b.push_back(exp_resp);
        repeat (bready_delay) @(posedge clock);
        #1;
        axi_bus.bready = 1'b1;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!axi_bus.bvalid && t < Tmo);
        if (!axi_bus.bvalid) fail_now("b_handshake");
        @(posedge clock); #1;
        axi_bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit toggle);
        int t;
        int got;
        axi_bus.araddr  = addr;
        axi_bus.arlen   = len;
        axi_bus.arburst = burst;
        axi_bus.arvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!axi_bus.arready && t < Tmo);
        if (!axi_bus.arready) fail_now("ar_handshake");
        @(posedge clock); #1;
        axi_bus.arvalid = 1'b0;
        got = 0;
        t = 0;
        while (got <= int'(len) && t < Tmo) begin
            axi_bus.rready = toggle ? (t % 2 == 0) : 1'b1;
            @(negedge clock);
            if (axi_bus.rvalid && axi_bus.rready) got++;
            @(posedge clock); #1;
            t++;
        end
        axi_bus.rready = 1'b0;
        if (got <= int'(len)) fail_now("r_beats");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axi_bus.awaddr = '0; axi_bus.awlen = '0; axi_bus.awburst = BurstIncr;
        axi_bus.awvalid = 1'b0;
        axi_bus.wdata = '0; axi_bus.wstrb = '0; axi_bus.wlast = 1'b0; axi_bus.wvalid = 1'b0;
        axi_bus.bready = 1'b0;
        axi_bus.araddr = '0; axi_bus.arlen = '0; axi_bus.arburst = BurstIncr;
        axi_bus.arvalid = 1'b0;
        axi_bus.rready = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_awready", 32'(axi_bus.awready), 32'h0);
        chk("rst_arready", 32'(axi_bus.arready), 32'h0);
        chk("rst_wready", 32'(axi_bus.wready), 32'h0);
        chk("rst_bvalid", 32'(axi_bus.bvalid), 32'h0);
        chk("rst_rvalid", 32'(axi_bus.rvalid), 32'h0);
        chk("rst_bresp", 32'(axi_bus.bresp), 32'h0);
        chk("rst_rresp", 32'(axi_bus.rresp), 32'h0);
        chk("rst_rdata", axi_bus.rdata, 32'h0);
        chk("rst_rlast", 32'(axi_bus.rlast), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_load_done", 32'(load_done), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // INCR write of words 4..7, BREADY delayed two cycles
        wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
        axi_write(32'h10, 8'd3, BurstIncr, 4'hF, 12'd4, 1'b1, RespOkay, 2);

        // INCR read-back with RREADY toggling
        push_r(32'hA0, RespOkay, 1'b0);
        push_r(32'hA1, RespOkay, 1'b0);
        push_r(32'hA2, RespOkay, 1'b0);
        push_r(32'hA3, RespOkay, 1'b1);
        axi_read(32'h10, 8'd3, BurstIncr, 1'b1);

        // Simultaneous AW and AR: write first, read sees new data
        axi_bus.araddr = 32'h50; axi_bus.arlen = 8'd0; axi_bus.arburst = BurstIncr;
        axi_bus.arvalid = 1'b1;
        ar_block = 1'b1;
        wbuf[0] = 32'h1234_5678;
        axi_write(32'h50, 8'd0, BurstIncr, 4'hF, 12'd20, 1'b1, RespOkay, 0);
        ar_block = 1'b0;
        push_r(32'h1234_5678, RespOkay, 1'b1);
        axi_read(32'h50, 8'd0, BurstIncr, 1'b0);

        // Burst crossing the top of memory: handshaked, never written
        wbuf[0] = 32'hC0; wbuf[1] = 32'hC1;
        axi_write(32'h3FFC, 8'd1, BurstIncr, 4'hF, 12'd0, 1'b0, RespSlverr, 0);
        push_r(32'h0, RespSlverr, 1'b0);
        push_r(32'h0, RespSlverr, 1'b1);
        axi_read(32'h3FFC, 8'd1, BurstIncr, 1'b0);

        // FIXED burst to word 9, low half only
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
        axi_write(32'h24, 8'd2, BurstFixed, 4'h3, 12'd9, 1'b1, RespOkay, 0);
        push_r(32'h0000_0003, RespOkay, 1'b1);
        axi_read(32'h24, 8'd0, BurstIncr, 1'b0);

        // Reset during the second beat of a 4-beat write to word 30
        wbuf[0] = 32'hD0; wbuf[1] = 32'hD1;
        axi_bus.awaddr = 32'h78; axi_bus.awlen = 8'd3; axi_bus.awburst = BurstIncr;
        axi_bus.awvalid = 1'b1;
        @(negedge clock);
        if (!axi_bus.awready) fail_now("aw_handshake_rst");
        @(posedge clock); #1;
        axi_bus.awvalid = 1'b0;
        axi_bus.wdata = wbuf[0]; axi_bus.wstrb = 4'hF; axi_bus.wlast = 1'b0;
        axi_bus.wvalid = 1'b1;
        @(negedge clock);
        if (!axi_bus.wready) fail_now("w_handshake_rst");
        exp_wr.push_back('{addr: 12'd30, we: 4'hF, data: wbuf[0], consec: 1'b0});
        @(posedge clock); #1;
        axi_bus.wdata = wbuf[1];
        @(negedge clock);
        #1;
        reset = 1'b0;
        axi_bus.wvalid = 1'b0;
        #1;
        chk("abort_wready", 32'(axi_bus.wready), 32'h0);
        chk("abort_bvalid", 32'(axi_bus.bvalid), 32'h0);
        chk("abort_mem_en", 32'(mem_en), 32'h0);
        chk("abort_mem_we", 32'(mem_we), 32'h0);
        chk("abort_load_done", 32'(load_done), 32'h0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("abort_no_b_pending", 32'(exp_b.size()), 32'h0);

        // Normal write after the aborted burst, then read back
        wbuf[0] = 32'hB0; wbuf[1] = 32'hB1;
        axi_write(32'hA0, 8'd1, BurstIncr, 4'hF, 12'd40, 1'b1, RespOkay, 1);
        push_r(32'hB0, RespOkay, 1'b0);
        push_r(32'hB1, RespOkay, 1'b1);
        axi_read(32'hA0, 8'd1, BurstIncr, 1'b0);

        repeat (4) @(posedge clock);
        #1;
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
        chk("b_queue_empty", 32'(exp_b.size()), 32'h0);
        chk("r_queue_empty", 32'(exp_r.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
